// File: rtl/countdown_pkg.sv
// Shared types and defaults for the loadable down-counter.
// Build option AUTO_RELOAD_EN (see countdown_core) does not affect this package.
package countdown_pkg;

  localparam int unsigned CD_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } cd_state_e;

  function automatic logic cd_is_idle(input cd_state_e st);
    return st == StIdle;
  endfunction

endpackage

// File: rtl/countdown_dec.sv
// WIDTH-bit ripple decrementer built from a borrow chain (XOR2T/AND2T style).
// Flags a value of exactly one so the caller can detect the terminal step.
module countdown_dec #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] diff,
  output logic             is_one
);

  logic [WIDTH-1:0] borrow;

  assign borrow[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
    assign borrow[i] = ~a[i-1] & borrow[i-1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_diff
    assign diff[i] = a[i] ^ borrow[i];
  end

  assign is_one = (a == WIDTH'(1));

endmodule

// File: rtl/countdown_core.sv
// Loadable down-counter with valid/ready load, enable, abort and a terminal-count pulse.
// Define AUTO_RELOAD_EN to keep running and reload the start value after each terminal count.
module countdown_core
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = CD_WIDTH_DEFAULT
) (
  input  logic             GCLK_Pad,
  input  logic             rst_Pad,
  input  logic             load_Pad,
  input  logic [WIDTH-1:0] load_val_Pad,
  input  logic             en_Pad,
  input  logic             stop_Pad,
  output logic             ready_Pad,
  output logic [WIDTH-1:0] count_Pad,
  output logic             tc_Pad
);

  cd_state_e        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] dec_diff;
  logic             dec_is_one;
  logic             is_zero;

  countdown_dec #(
    .WIDTH (WIDTH)
  ) u_dec (
    .a      (count_q),
    .diff   (dec_diff),
    .is_one (dec_is_one)
  );

  assign is_zero = (count_q == '0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (load_Pad) begin
          count_d  = load_val_Pad;
          reload_d = load_val_Pad;
          if (load_val_Pad == '0) begin
            state_d = StDone;
            tc_d    = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        // Abort wins over both decrement and terminal count.
        if (stop_Pad) begin
          state_d = StIdle;
        end else if (en_Pad) begin
          if (dec_is_one) begin
            count_d = '0;
            tc_d    = 1'b1;
`ifdef AUTO_RELOAD_EN
            state_d = StRun;
`else
            state_d = StDone;
`endif
          end else if (is_zero) begin
`ifdef AUTO_RELOAD_EN
            count_d = reload_q;
`else
            count_d = count_q;
`endif
          end else begin
            count_d = dec_diff;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered copy of the next state's idle flag keeps ready glitch-free.
    ready_d = cd_is_idle(state_d);
  end

  always_ff @(posedge GCLK_Pad or posedge rst_Pad) begin
    if (rst_Pad) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      ready_q  <= ready_d;
    end
  end

  assign ready_Pad = ready_q;
  assign count_Pad = count_q;
  assign tc_Pad    = tc_q;

endmodule
